// File: rtl/player_ctrl_1.sv
// Level-1 player movement controller: buttons -> sprite x/y and animation state, updated per vsync frame.
// Optional jump physics enabled by defining PLAYER_JUMP_EN.

package state_pkg;
  typedef enum logic [1:0] {
    IDLE1  = 2'd0,
    RIGHT1 = 2'd1,
    LEFT1  = 2'd2
  } State1;
endpackage

module player_ctrl_1
  import state_pkg::*;
#(
  parameter int X_INIT    = 100,
  parameter int XMIN      = 0,
  parameter int XMAX      = 984,
  parameter int STEP      = 4,
  parameter int IDLE_HOLD = 4,
  parameter int JUMP_V0   = 12,
  parameter int GRAVITY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [11:0] xpos_player1,
  output logic [11:0] ypos_player1,
  output State1       state,
  output logic        moving
);

  localparam int CW = (IDLE_HOLD > 1) ? $clog2(IDLE_HOLD) : 1;

  logic          left_s1, left_s2, right_s1, right_s2;
  logic          vsync_prev;
  logic          tick;
  logic          go_r, go_l;
  logic [CW-1:0] idle_cnt, idle_n;
  logic [11:0]   xpos_n;
  State1         state_n;
  logic          moving_n;

  assign tick = vsync & ~vsync_prev;
  assign go_r = right_s2 & ~left_s2;
  assign go_l = left_s2 & ~right_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      left_s1      <= 1'b0;
      left_s2      <= 1'b0;
      right_s1     <= 1'b0;
      right_s2     <= 1'b0;
      vsync_prev   <= 1'b1;
      xpos_player1 <= 12'(X_INIT);
      state        <= IDLE1;
      moving       <= 1'b0;
      idle_cnt     <= '0;
    end else begin
      left_s1      <= btn_left;
      left_s2      <= left_s1;
      right_s1     <= btn_right;
      right_s2     <= right_s1;
      vsync_prev   <= vsync;
      xpos_player1 <= xpos_n;
      state        <= state_n;
      moving       <= moving_n;
      idle_cnt     <= idle_n;
    end
  end

  // Walking pose lingers for IDLE_HOLD empty frames before dropping back to idle.
  always_comb begin
    state_n  = state;
    idle_n   = idle_cnt;
    xpos_n   = xpos_player1;
    moving_n = moving;
    if (tick) begin
      if (go_r)
        xpos_n = (xpos_player1 > 12'(XMAX - STEP)) ? 12'(XMAX) : xpos_player1 + 12'(STEP);
      else if (go_l)
        xpos_n = (xpos_player1 < 12'(XMIN + STEP)) ? 12'(XMIN) : xpos_player1 - 12'(STEP);
      moving_n = (xpos_n != xpos_player1);
      case (state)
        IDLE1: begin
          idle_n = '0;
          if (go_r)      state_n = RIGHT1;
          else if (go_l) state_n = LEFT1;
        end
        default: begin
          if (go_r) begin
            state_n = RIGHT1;
            idle_n  = '0;
          end else if (go_l) begin
            state_n = LEFT1;
            idle_n  = '0;
          end else if (idle_cnt == CW'(IDLE_HOLD - 1)) begin
            state_n = IDLE1;
            idle_n  = '0;
          end else begin
            idle_n = idle_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PLAYER_JUMP_EN
  logic              jump_s1, jump_s2, jump_prev, jump_pend, pend_n;
  logic              jump_rise, grounded, launch;
  logic signed [7:0] vel, vel_n, vel_eff;
  logic signed [12:0] ysum;
  logic [11:0]       ypos, ypos_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      jump_s1   <= 1'b0;
      jump_s2   <= 1'b0;
      jump_prev <= 1'b0;
      jump_pend <= 1'b0;
      vel       <= '0;
      ypos      <= '0;
    end else begin
      jump_s1   <= btn_jump;
      jump_s2   <= jump_s1;
      jump_prev <= jump_s2;
      jump_pend <= pend_n;
      vel       <= vel_n;
      ypos      <= ypos_n;
    end
  end

  // A launch applies its first velocity step in the same frame, so ypos reads JUMP_V0 right away.
  always_comb begin
    jump_rise = jump_s2 & ~jump_prev;
    grounded  = (ypos == '0) && (vel == '0);
    launch    = tick & (jump_pend | jump_rise) & grounded;
    vel_eff   = launch ? 8'(JUMP_V0) : vel;
    ysum      = $signed({1'b0, ypos}) + $signed({{5{vel_eff[7]}}, vel_eff});
    pend_n    = tick ? 1'b0 : (jump_pend | jump_rise);
    ypos_n    = ypos;
    vel_n     = vel;
    if (tick && (launch || !grounded)) begin
      if (ysum <= 13'sd0) begin
        ypos_n = '0;
        vel_n  = '0;
      end else begin
        ypos_n = ysum[11:0];
        vel_n  = vel_eff - 8'(GRAVITY);
      end
    end
  end

  assign ypos_player1 = ypos;
`else
  logic unused_jump;
  assign unused_jump  = btn_jump;
  assign ypos_player1 = '0;
`endif

endmodule
